// File: rtl/px_stats_pkg.sv
// Shared definitions for the per-frame colour statistics block and its
// classifier: colour codes, controller state encoding and default sizing.
package px_stats_pkg;

    typedef enum logic [1:0] {
        COL_NONE  = 2'b00,
        COL_RED   = 2'b01,
        COL_GREEN = 2'b10,
        COL_BLUE  = 2'b11
    } color_t;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_VBL    = 3'd1,
        S_COUNT  = 3'd2,
        S_DECIDE = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    // 160x120 frame
    localparam int FRAME_PX_DEF = 19200;

endpackage

// File: rtl/px_classify.sv
// Combinational RGB332 colour classifier. A pixel is "red", "green" or
// "blue" only when its own channel is strong and the other two are weak;
// everything else is "other" (COL_NONE). Shared with display overlay logic.
module px_classify
    import px_stats_pkg::*;
#(
    parameter logic [2:0] HI3 = 3'd5,
    parameter logic [2:0] LO3 = 3'd2,
    parameter logic [1:0] HI2 = 2'd2,
    parameter logic [1:0] LO2 = 2'd1
) (
    input  logic [7:0] px_data,
    output color_t     px_class
);

    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;

    assign r = px_data[7:5];
    assign g = px_data[4:2];
    assign b = px_data[1:0];

    // Strong-channel / weak-others test; the three classes cannot overlap
    always_comb begin
        // NOTE: default assignment first so every path drives px_class and no latch is inferred.
        px_class = COL_NONE;
        if (r >= HI3 && g <= LO3 && b <= LO2)
            px_class = COL_RED;
        else if (g >= HI3 && r <= LO3 && b <= LO2)
            px_class = COL_GREEN;
        else if (b >= HI2 && r <= LO3 && g <= LO3)
            px_class = COL_BLUE;
    end

endmodule

// File: rtl/px_color_stats.sv
// Per-frame colour statistics on the capture write stream (pclk domain).
// Counts red/green/blue/total pixel writes between vsync blanking periods
// and, after each frame, publishes the dominant colour and the counts with
// a one-cycle result_valid strobe.
module px_color_stats
    import px_stats_pkg::*;
#(
    parameter int         AW       = 15,
    parameter int         FRAME_PX = FRAME_PX_DEF,
    parameter int         MIN_PIX  = 1000,
    parameter logic [2:0] HI3      = 3'd5,
    parameter logic [2:0] LO3      = 3'd2,
    parameter logic [1:0] HI2      = 2'd2,
    parameter logic [1:0] LO2      = 2'd1
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          px_wr,
    input  logic [7:0]    px_data,
    output logic          result_valid,
    output logic [1:0]    color,
    output logic [AW-1:0] red_cnt,
    output logic [AW-1:0] green_cnt,
    output logic [AW-1:0] blue_cnt,
    output logic [AW-1:0] px_cnt,
    output logic          frame_err
);

    localparam logic [AW-1:0] MIN_V   = AW'(MIN_PIX);
    localparam logic [AW-1:0] FRAME_V = AW'(FRAME_PX);

    state_t        state;
    logic          px_wr_q;
    logic [AW-1:0] r_acc, g_acc, b_acc, n_acc;
    color_t        px_class;
    color_t        win, win_q;
    logic [AW-1:0] max_cnt;
    logic          px_event;

    px_classify #(
        .HI3 (HI3),
        .LO3 (LO3),
        .HI2 (HI2),
        .LO2 (LO2)
    ) u_classify (
        .px_data  (px_data),
        .px_class (px_class)
    );

    // One event per px_wr rising edge, never during vertical blanking
    assign px_event = px_wr && !px_wr_q && !vsync;

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Dominant colour: strict '>' keeps red ahead of green ahead of blue on ties
    always_comb begin
        win     = COL_RED;
        max_cnt = r_acc;
        if (g_acc > max_cnt) begin
            win     = COL_GREEN;
            max_cnt = g_acc;
        end
        if (b_acc > max_cnt) begin
            win     = COL_BLUE;
            max_cnt = b_acc;
        end
        if (max_cnt < MIN_V || max_cnt == '0)
            win = COL_NONE;
    end

    // Frame controller, accumulators and registered result outputs
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state        <= S_WAIT;
            px_wr_q      <= 1'b0;
            r_acc        <= '0;
            g_acc        <= '0;
            b_acc        <= '0;
            n_acc        <= '0;
            win_q        <= COL_NONE;
            result_valid <= 1'b0;
            color        <= 2'b00;
            red_cnt      <= '0;
            green_cnt    <= '0;
            blue_cnt     <= '0;
            px_cnt       <= '0;
            frame_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            px_wr_q      <= px_wr;
            result_valid <= 1'b0;
            case (state)
                S_WAIT: begin
                    // Partial frame after reset is skipped until blanking
                    if (vsync)
                        state <= S_VBL;
                end
                S_VBL: begin
                    if (!vsync) begin
                        state <= S_COUNT;
                        r_acc <= '0;
                        g_acc <= '0;
                        b_acc <= '0;
                        n_acc <= '0;
                    end
                end
                S_COUNT: begin
                    if (vsync) begin
                        state <= S_DECIDE;
                    end else if (px_event) begin
                        n_acc <= sat_inc(n_acc);
                        case (px_class)
                            COL_RED:   r_acc <= sat_inc(r_acc);
                            COL_GREEN: g_acc <= sat_inc(g_acc);
                            COL_BLUE:  b_acc <= sat_inc(b_acc);
                            default:   ;
                        endcase
                    end
                end
                S_DECIDE: begin
                    win_q <= win;
                    state <= S_OUT;
                end
                S_OUT: begin
                    color        <= win_q;
                    red_cnt      <= r_acc;
                    green_cnt    <= g_acc;
                    blue_cnt     <= b_acc;
                    px_cnt       <= n_acc;
                    frame_err    <= (n_acc != FRAME_V);
                    result_valid <= 1'b1;
                    state        <= S_VBL;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_px_color_stats.sv
// Self-checking bench for px_color_stats. Pixels credited to a frame are kept
// in a queue; at vsync the expected counts, colour and frame_err are derived
// from that queue with plain arithmetic on the colour rules.
// The frame length is shortened to 4000 pixels to keep run time short; the
// colour thresholds keep their default values.
module tb_px_color_stats;

    localparam int AW          = 15;
    localparam int TB_FRAME_PX = 4000;
    localparam int TB_MIN_PIX  = 1000;

    logic          pclk = 1'b0;
    logic          rst  = 1'b0;
    logic          vsync = 1'b0;
    logic          px_wr = 1'b0;
    logic [7:0]    px_data = 8'h00;
    logic          result_valid;
    logic [1:0]    color;
    logic [AW-1:0] red_cnt, green_cnt, blue_cnt, px_cnt;
    logic          frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    px_color_stats #(
        .AW       (AW),
        .FRAME_PX (TB_FRAME_PX),
        .MIN_PIX  (TB_MIN_PIX)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .vsync        (vsync),
        .px_wr        (px_wr),
        .px_data      (px_data),
        .result_valid (result_valid),
        .color        (color),
        .red_cnt      (red_cnt),
        .green_cnt    (green_cnt),
        .blue_cnt     (blue_cnt),
        .px_cnt       (px_cnt),
        .frame_err    (frame_err)
    );

    always #5 pclk = ~pclk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference classification: 1 red, 2 green, 3 blue, 0 other
    function automatic int cls(input int p);
        int r = p / 32;
        int g = (p / 4) % 8;
        int b = p % 4;
        if (r >= 5 && g <= 2 && b <= 1) return 1;
        if (g >= 5 && r <= 2 && b <= 1) return 2;
        if (b >= 2 && r <= 2 && g <= 2) return 3;
        return 0;
    endfunction

    // Capture drives on the falling edge
    task automatic step(input logic v, input logic w, input logic [7:0] d);
        @(negedge pclk);
        vsync   = v;
        px_wr   = w;
        px_data = d;
    endtask

    task automatic pixel(input logic [7:0] d);
        step(1'b0, 1'b1, d);
        exp_q.push_back(int'(d));
        step(1'b0, 1'b0, d);
    endtask

    task automatic pixels(input int n, input logic [7:0] d);
        repeat (n) pixel(d);
    endtask

    task automatic held_pixel(input logic [7:0] d, input int cycles);
        step(1'b0, 1'b1, d);
        exp_q.push_back(int'(d));
        repeat (cycles - 1) step(1'b0, 1'b1, d);
        step(1'b0, 1'b0, d);
    endtask

    task automatic start_frame(input int blank_pulses);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        repeat (blank_pulses) begin
            step(1'b1, 1'b1, 8'hE0);
            step(1'b1, 1'b0, 8'h00);
        end
        step(1'b0, 1'b0, 8'h00);
        exp_q.delete();
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " result_valid"}, result_valid, 0);
        check({tag, " color"},        color, 0);
        check({tag, " red_cnt"},      red_cnt, 0);
        check({tag, " green_cnt"},    green_cnt, 0);
        check({tag, " blue_cnt"},     blue_cnt, 0);
        check({tag, " px_cnt"},       px_cnt, 0);
        check({tag, " frame_err"},    frame_err, 0);
    endtask

    // Raise vsync, wait for the report and compare it with the model
    task automatic end_frame(input string tag, input logic wr_edge);
        int r = 0, g = 0, b = 0, n, mx, col, lat = 0;
        int sat = (1 << AW) - 1;
        foreach (exp_q[i]) begin
            case (cls(exp_q[i]))
                1: r++;
                2: g++;
                3: b++;
                default: ;
            endcase
        end
        n = exp_q.size();
        if (r > sat) r = sat;
        if (g > sat) g = sat;
        if (b > sat) b = sat;
        if (n > sat) n = sat;
        if (r >= g && r >= b) begin col = 1; mx = r; end
        else if (g >= b)      begin col = 2; mx = g; end
        else                  begin col = 3; mx = b; end
        if (mx < TB_MIN_PIX || mx == 0) col = 0;

        step(1'b1, wr_edge, 8'hE0);
        for (int c = 1; c <= 8; c++) begin
            @(posedge pclk);
            #1;
            if (result_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"},   lat, 3);
        check({tag, " color"},     color, col);
        check({tag, " red_cnt"},   red_cnt, r);
        check({tag, " green_cnt"}, green_cnt, g);
        check({tag, " blue_cnt"},  blue_cnt, b);
        check({tag, " px_cnt"},    px_cnt, n);
        check({tag, " frame_err"}, frame_err, (n != TB_FRAME_PX));
        @(posedge pclk);
        #1;
        check({tag, " pulse width"}, result_valid, 0);
        check({tag, " color hold"},  color, col);
        check({tag, " px_cnt hold"}, px_cnt, n);
    endtask

    initial begin
        // 1. Reset with random activity on the inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            rst     = 1'b0;
            vsync   = 1'($urandom);
            px_wr   = 1'($urandom);
            px_data = 8'($urandom);
            @(posedge pclk);
            #1;
            check_zero("reset");
        end
        @(negedge pclk);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        @(posedge pclk);
        #1;
        check_zero("post reset");

        // 2. Red majority, full-length frame
        start_frame(0);
        pixels(2500, 8'hE0);
        pixels(TB_FRAME_PX - 2500, 8'h00);
        end_frame("red frame", 1'b0);

        // 3. Blue below MIN_PIX
        start_frame(0);
        pixels(500, 8'h03);
        pixels(TB_FRAME_PX - 500, 8'h00);
        end_frame("weak blue", 1'b0);

        // 4. Red/green tie resolved to red
        start_frame(0);
        pixels(1500, 8'hE0);
        pixels(1500, 8'h1C);
        pixels(TB_FRAME_PX - 3000, 8'h00);
        end_frame("tie", 1'b0);

        // 5. Short frame: held write, blanking pulses, write on vsync edge
        start_frame(5);
        pixels(50, 8'h00);
        held_pixel(8'hE0, 10);
        pixels(49, 8'h03);
        end_frame("short frame", 1'b1);

        // MIN_PIX boundary on both sides
        start_frame(0);
        pixels(TB_MIN_PIX, 8'h03);
        end_frame("min_pix exact", 1'b0);
        start_frame(0);
        pixels(TB_MIN_PIX - 1, 8'hE0);
        end_frame("min_pix minus one", 1'b0);

        // Randomized frames: random data, gaps and hold lengths
        for (int f = 0; f < 2; f++) begin
            int nev = (f == 0) ? int'($urandom_range(50, 400)) : 1300;
            start_frame(int'($urandom_range(0, 3)));
            for (int i = 0; i < nev; i++) begin
                logic [7:0] d = 8'($urandom);
                if (f == 1 && $urandom_range(0, 9) < 7)
                    d = {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 1))};
                held_pixel(d, int'($urandom_range(1, 3)));
                repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, d);
            end
            end_frame(f == 0 ? "random small" : "random red-heavy", 1'($urandom));
        end

        // 6. Reset mid-frame: frame dropped, next full frame reported
        start_frame(0);
        pixels(2000, 8'hE0);
        @(negedge pclk);
        rst = 1'b0;
        @(posedge pclk);
        #1;
        check_zero("mid-frame reset");
        @(negedge pclk);
        rst = 1'b1;
        pixels(200, 8'hE0);
        step(1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 6; c++) begin
            @(posedge pclk);
            #1;
            check("dropped frame no result", result_valid, 0);
        end
        start_frame(0);
        pixels(TB_FRAME_PX, 8'h1C);
        end_frame("green frame", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
